// File: rtl/uart_rx_module_if.sv
// Receiver-side bundle: serial input, consumer acknowledge and the received-byte/status outputs.
interface uart_rx_module_if;
    logic       rx_in;
    logic       rx_ack;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    // Receiver side: samples the line and reports bytes and errors.
    modport slave (
        input  rx_in,
        input  rx_ack,
        output data_out,
        output rx_valid,
        output frame_err,
        output overrun_err,
        output busy
    );

    // Line driver / consumer side.
    modport master (
        output rx_in,
        output rx_ack,
        input  data_out,
        input  rx_valid,
        input  frame_err,
        input  overrun_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx_module.sv
// 8N1 UART receiver, LSB first, idle high. Samples each data bit at the
// middle of its period, holds the last good byte with a sticky valid flag,
// and reports framing and overrun errors.
module uart_rx_module #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    uart_rx_module_if.slave   bus
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       dataOut_q, dataOut_d;
    logic             rxValid_q, rxValid_d;
    logic             frameErr_q, frameErr_d;
    logic             overrun_q, overrun_d;
    logic             rxMeta_q, rxSync_q;
    logic             goodStop;

    // Two-flop synchronizer on the asynchronous line; resets to the idle level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= bus.rx_in;
            rxSync_q <= rxMeta_q;
        end
    end

    // State, counters, shift register and output flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            dataOut_q  <= '0;
            rxValid_q  <= 1'b0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            dataOut_q  <= dataOut_d;
            rxValid_q  <= rxValid_d;
            frameErr_q <= frameErr_d;
            overrun_q  <= overrun_d;
        end
    end

    // Frame sequencing plus the valid/overrun handshake; cnt restarts on every state change.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        shift_d    = shift_q;
        dataOut_d  = dataOut_q;
        rxValid_d  = rxValid_q;
        overrun_d  = overrun_q;
        frameErr_d = 1'b0;
        goodStop   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxSync_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxSync_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxSync_q;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxSync_q) begin
                        goodStop = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        frameErr_d = 1'b1;
                        state_d    = BREAK_WAIT;
                    end
                end
            end
            BREAK_WAIT: begin
                cnt_d = '0;
                if (rxSync_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (goodStop) begin
            dataOut_d = shift_q;
            rxValid_d = 1'b1;
            if (rxValid_q && !bus.rx_ack) begin
                overrun_d = 1'b1;
            end else if (bus.rx_ack) begin
                overrun_d = 1'b0;
            end
        end else if (bus.rx_ack && rxValid_q) begin
            rxValid_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    assign bus.data_out    = dataOut_q;
    assign bus.rx_valid    = rxValid_q;
    assign bus.frame_err   = frameErr_q;
    assign bus.overrun_err = overrun_q;
    assign bus.busy        = (state_q != IDLE);

endmodule
